payload_extractor: RTL and testbench

- Upstream feeder for the string comparator.
- Accepts a 32-bit word stream of received Ethernet frames with start/end markers, discards a fixed number of header words, and forwards payload words on a registered 32-bit bus.
- After each frame it drives zero filler words so the comparator pipeline drains, then pulses clear for one cycle so the comparator is reset for the next frame.

---
 rtl/payload_extractor_if.sv | 23 ++
 rtl/payload_extractor.sv | 163 ++++++++++++++++
 tb/tb_payload_extractor.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/payload_extractor_if.sv
// Word-stream bus between the frame receiver, the payload extractor and the
// string comparator. The receiver side (master) drives the rx_* word stream
// and the extractor side (slave) drives the comparator-facing outputs.
interface payload_extractor_if;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic [31:0] data_out;
  logic        payload_valid;
  logic        clear;
  logic        busy;

  modport master (
    output rx_data, rx_valid, rx_sof, rx_eof,
    input  data_out, payload_valid, clear, busy
  );

  modport slave (
    input  rx_data, rx_valid, rx_sof, rx_eof,
    output data_out, payload_valid, clear, busy
  );
endinterface

// File: rtl/payload_extractor.sv
// payload_extractor: strips HDR_WORDS header words from each received frame,
// forwards the payload words one cycle later, then emits FLUSH_WORDS cycles
// of zero words and a one-cycle clear so the comparator drains and restarts.
// Optional build macro EXTRACT_STATS_EN adds saturating frame_count and
// drop_count outputs; the core behaviour is identical with or without it.
// Every output register holds the value belonging to the state being
// entered, so clear and busy line up exactly with the CLEAR state.
module payload_extractor #(
  parameter int HDR_WORDS   = 4,
  parameter int FLUSH_WORDS = 10
) (
  input  logic clk,
  input  logic n_rst,
  payload_extractor_if.slave bus
`ifdef EXTRACT_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    FLUSH,
    CLEAR
  } state_t;

  localparam logic [7:0] HDR_LAST   = 8'(HDR_WORDS);
  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_WORDS - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  hdr_cnt;
  logic [7:0]  hdr_cnt_next;
  logic [7:0]  flush_cnt;
  logic [7:0]  flush_cnt_next;
  logic [31:0] data_q;
  logic [31:0] data_next;
  logic        valid_q;
  logic        valid_next;
  logic        clear_q;
  logic        busy_q;
  logic        sof_in;
  logic        eof_in;

  assign sof_in = bus.rx_valid && bus.rx_sof;
  assign eof_in = bus.rx_valid && bus.rx_eof;

  assign bus.data_out      = data_q;
  assign bus.payload_valid = valid_q;
  assign bus.clear         = clear_q;
  assign bus.busy          = busy_q;

  // Next-state, counter and forwarded-word decisions for the frame sequencer.
  always_comb begin
    next_state     = state;
    hdr_cnt_next   = hdr_cnt;
    flush_cnt_next = flush_cnt;
    data_next      = '0;
    valid_next     = 1'b0;

    case (state)
      IDLE: begin
        if (sof_in) begin
          hdr_cnt_next = 8'd1;
          if (bus.rx_eof) begin
            next_state = CLEAR;
          end else if (HDR_WORDS == 1) begin
            next_state = PAYLOAD;
          end else begin
            next_state = HEADER;
          end
        end
      end

      HEADER: begin
        // A new sof here means the frame never reached its payload, so there
        // is nothing in the comparator to drain and we go straight to clear.
        if (sof_in) begin
          next_state = CLEAR;
        end else if (bus.rx_valid) begin
          hdr_cnt_next = hdr_cnt + 8'd1;
          if (eof_in) begin
            next_state = CLEAR;
          end else if ((hdr_cnt + 8'd1) == HDR_LAST) begin
            next_state = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        // The sof word belongs to the dropped new frame and is not forwarded.
        if (sof_in) begin
          next_state     = FLUSH;
          flush_cnt_next = 8'd0;
        end else if (bus.rx_valid) begin
          data_next  = bus.rx_data;
          valid_next = 1'b1;
          if (bus.rx_eof) begin
            next_state     = FLUSH;
            flush_cnt_next = 8'd0;
          end
        end
      end

      FLUSH: begin
        flush_cnt_next = flush_cnt + 8'd1;
        if (flush_cnt == FLUSH_LAST) begin
          next_state = CLEAR;
        end
      end

      CLEAR: begin
        next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, counters and registered comparator-facing outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      hdr_cnt   <= '0;
      flush_cnt <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      clear_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= next_state;
      hdr_cnt   <= hdr_cnt_next;
      flush_cnt <= flush_cnt_next;
      data_q    <= data_next;
      valid_q   <= valid_next;
      clear_q   <= (next_state == CLEAR);
      busy_q    <= (next_state != IDLE);
    end
  end

`ifdef EXTRACT_STATS_EN
  // Saturating counts of completed frames and of start-of-frame words refused.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if ((next_state == CLEAR) && (frame_count != 16'hFFFF)) begin
        frame_count <= frame_count + 16'd1;
      end
      if (sof_in && (state != IDLE) && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_payload_extractor.sv
// Testbench for payload_extractor (HDR_WORDS=4, FLUSH_WORDS=10).
// Frames are laid out on a cycle timeline; the expected output timeline is
// derived from frame-level rules: payload words appear one cycle after they
// are received, clear and the end of busy fall FLUSH_WORDS cycles after the
// last payload-phase word, or on the eof/sof word itself for header-only or
// header-truncated frames. Stats are checked when EXTRACT_STATS_EN is set.
module tb_payload_extractor;
  localparam int HDR   = 4;
  localparam int FLUSH = 10;
  localparam int MAXC  = 400;

  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  payload_extractor_if bus();

`ifdef EXTRACT_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] drop_count;
`endif

  payload_extractor #(
    .HDR_WORDS  (HDR),
    .FLUSH_WORDS(FLUSH)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
`ifdef EXTRACT_STATS_EN
    ,
    .frame_count(frame_count),
    .drop_count (drop_count)
`endif
  );

  int total = 0;
  int bad   = 0;
  int exp_frames = 0;
  int exp_drops  = 0;

  logic        s_valid [MAXC];
  logic        s_sof   [MAXC];
  logic        s_eof   [MAXC];
  logic [31:0] s_data  [MAXC];
  logic [31:0] e_data  [MAXC];
  logic        e_pv    [MAXC];
  logic        e_clr   [MAXC];
  logic        e_busy  [MAXC];
  logic [34:0] o_vec   [MAXC];
  logic [31:0] word_q[$];
  int          gap_q[$];

  task automatic rx_idle();
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
    bus.rx_eof   = 1'b0;
    bus.rx_data  = '0;
  endtask

  task automatic clear_trace();
    for (int k = 0; k < MAXC; k++) begin
      s_valid[k] = 1'b0;
      s_sof[k]   = 1'b0;
      s_eof[k]   = 1'b0;
      s_data[k]  = $urandom;
      e_data[k]  = '0;
      e_pv[k]    = 1'b0;
      e_clr[k]   = 1'b0;
      e_busy[k]  = 1'b0;
    end
    word_q.delete();
    gap_q.delete();
  endtask

  // Place one frame on the timeline and derive its expected outputs.
  // trunc: the last word is a new sof that cuts the frame short.
  task automatic add_frame(input int start, input int nwords, input int max_gap,
                           input bit trunc, output int end_c);
    int c;
    int last;
    int g;
    logic [31:0] w;
    c = start;
    last = start;
    for (int k = 0; k < nwords; k++) begin
      w = (word_q.size() > 0) ? word_q.pop_front() : $urandom;
      s_valid[c] = 1'b1;
      s_data[c]  = w;
      s_sof[c]   = (k == 0) || (trunc && (k == nwords - 1));
      s_eof[c]   = !trunc && (k == nwords - 1);
      if ((k >= HDR) && !(trunc && (k == nwords - 1))) begin
        e_data[c] = w;
        e_pv[c]   = 1'b1;
      end
      last = c;
      if (k < nwords - 1) begin
        g = (gap_q.size() > 0) ? gap_q.pop_front() : int'($urandom_range(max_gap, 0));
        c = c + 1 + g;
      end
    end
    if (trunc) end_c = (nwords - 1 >= HDR) ? last + FLUSH : last;
    else       end_c = (nwords > HDR) ? last + FLUSH : last;
    e_clr[end_c] = 1'b1;
    for (int b = start; b <= end_c; b++) e_busy[b] = 1'b1;
  endtask

  // Drive the timeline, capture outputs just after each edge, and tally the
  // frames/drops the timeline implies (a sof is refused unless idle before it).
  task automatic run_trace(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.rx_valid = s_valid[k];
      bus.rx_sof   = s_sof[k];
      bus.rx_eof   = s_eof[k];
      bus.rx_data  = s_data[k];
      @(posedge clk);
      #1;
      o_vec[k] = {bus.data_out, bus.payload_valid, bus.clear, bus.busy};
    end
    @(negedge clk);
    rx_idle();
    for (int k = 1; k < n; k++) begin
      if (s_valid[k] && s_sof[k] && e_busy[k-1]) exp_drops++;
      if (e_clr[k]) exp_frames++;
    end
  endtask

  task automatic test_reset();
    rx_idle();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.data_out, bus.payload_valid, bus.clear, bus.busy} !== 35'd0) begin
      bad++;
      $display("[TB] FAIL reset_values got=%h want=%h",
               {bus.data_out, bus.payload_valid, bus.clear, bus.busy}, 35'd0);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_sof   = (k == 0);
      bus.rx_eof   = 1'b0;
      bus.rx_data  = 32'hA000_0000 + k;
    end
    @(posedge clk);
    #1;
    total++;
    if ({bus.data_out, bus.payload_valid, bus.clear, bus.busy} !== {32'hA000_0005, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL pre_reset_payload got=%h want=%h",
               {bus.data_out, bus.payload_valid, bus.clear, bus.busy},
               {32'hA000_0005, 1'b1, 1'b0, 1'b1});
    end
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if ({bus.data_out, bus.payload_valid, bus.clear, bus.busy} !== 35'd0) begin
      bad++;
      $display("[TB] FAIL async_reset got=%h want=%h",
               {bus.data_out, bus.payload_valid, bus.clear, bus.busy}, 35'd0);
    end
    exp_frames = 0;
    exp_drops  = 0;
`ifdef EXTRACT_STATS_EN
    total++;
    if ({frame_count, drop_count} !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_stats got=%h want=%h", {frame_count, drop_count}, 32'd0);
    end
`endif
    @(negedge clk);
    rx_idle();
    n_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_sof   = 1'b0;
      bus.rx_eof   = (k == 2);
      bus.rx_data  = $urandom;
      @(posedge clk);
      #1;
      total++;
      if ({bus.data_out, bus.payload_valid, bus.clear, bus.busy} !== 35'd0) begin
        bad++;
        $display("[TB] FAIL no_sof_ignored cyc%0d got=%h want=%h", k,
                 {bus.data_out, bus.payload_valid, bus.clear, bus.busy}, 35'd0);
      end
    end
    @(negedge clk);
    rx_idle();
  endtask

  task automatic test_normal_frame();
    int e;
    clear_trace();
    for (int k = 0; k < HDR; k++) word_q.push_back($urandom);
    word_q.push_back(32'h7777_772E);
    word_q.push_back(32'h676F_6F67);
    word_q.push_back(32'h6C65_2E63);
    word_q.push_back(32'h6F6D_2020);
    add_frame(1, HDR + 4, 0, 1'b0, e);
    run_trace(e + 3);
    for (int k = 0; k < e + 3; k++) begin
      total++;
      if (o_vec[k] !== {e_data[k], e_pv[k], e_clr[k], e_busy[k]}) begin
        bad++;
        $display("[TB] FAIL normal cyc%0d got=%h want=%h", k, o_vec[k],
                 {e_data[k], e_pv[k], e_clr[k], e_busy[k]});
      end
    end
  endtask

  task automatic test_gap();
    int e;
    clear_trace();
    for (int k = 0; k < HDR + 1; k++) gap_q.push_back(0);
    gap_q.push_back(2);
    gap_q.push_back(0);
    add_frame(2, HDR + 4, 0, 1'b0, e);
    run_trace(e + 3);
    for (int k = 0; k < e + 3; k++) begin
      total++;
      if (o_vec[k] !== {e_data[k], e_pv[k], e_clr[k], e_busy[k]}) begin
        bad++;
        $display("[TB] FAIL gap cyc%0d got=%h want=%h", k, o_vec[k],
                 {e_data[k], e_pv[k], e_clr[k], e_busy[k]});
      end
    end
  endtask

  task automatic test_short_frames();
    int e1;
    int e2;
    clear_trace();
    add_frame(1, 3, 1, 1'b0, e1);
    add_frame(e1 + 2, 1, 0, 1'b0, e2);
    run_trace(e2 + 3);
    for (int k = 0; k < e2 + 3; k++) begin
      total++;
      if (o_vec[k] !== {e_data[k], e_pv[k], e_clr[k], e_busy[k]}) begin
        bad++;
        $display("[TB] FAIL short_frames cyc%0d got=%h want=%h", k, o_vec[k],
                 {e_data[k], e_pv[k], e_clr[k], e_busy[k]});
      end
    end
  endtask

  task automatic test_truncation();
    int e;
    int fr0;
    int dr0;
    fr0 = exp_frames;
    dr0 = exp_drops;
    clear_trace();
    add_frame(1, HDR + 2, 0, 1'b1, e);
    s_valid[e - FLUSH + 3] = 1'b1;
    s_sof[e - FLUSH + 3]   = 1'b1;
    s_valid[e - FLUSH + 5] = 1'b1;
    s_eof[e - FLUSH + 5]   = 1'b1;
    run_trace(e + 3);
    for (int k = 0; k < e + 3; k++) begin
      total++;
      if (o_vec[k] !== {e_data[k], e_pv[k], e_clr[k], e_busy[k]}) begin
        bad++;
        $display("[TB] FAIL truncation cyc%0d got=%h want=%h", k, o_vec[k],
                 {e_data[k], e_pv[k], e_clr[k], e_busy[k]});
      end
    end
    total++;
    if ((exp_frames - fr0 != 1) || (exp_drops - dr0 != 2)) begin
      bad++;
      $display("[TB] FAIL truncation_model frames=%0d drops=%0d want 1 and 2",
               exp_frames - fr0, exp_drops - dr0);
    end
`ifdef EXTRACT_STATS_EN
    total++;
    if ({frame_count, drop_count} !== {16'(exp_frames), 16'(exp_drops)}) begin
      bad++;
      $display("[TB] FAIL truncation_stats got frames=%0d drops=%0d want frames=%0d drops=%0d",
               frame_count, drop_count, exp_frames, exp_drops);
    end
`endif
  endtask

  task automatic test_random();
    int c;
    int e;
    int nw;
    bit tr;
    for (int round = 0; round < 3; round++) begin
      clear_trace();
      c = 1;
      for (int f = 0; f < 4; f++) begin
        tr = ($urandom_range(9, 0) < 3);
        nw = tr ? int'($urandom_range(HDR + 4, 2)) : int'($urandom_range(HDR + 5, 1));
        add_frame(c, nw, 2, tr, e);
        if ($urandom_range(3, 0) == 0) begin
          s_valid[e + 1] = 1'b1;
          s_sof[e + 1]   = 1'b1;
          s_eof[e + 1]   = 1'b1;
        end
        c = e + 2 + int'($urandom_range(2, 0));
      end
      run_trace(c + 2);
      for (int k = 0; k < c + 2; k++) begin
        total++;
        if (o_vec[k] !== {e_data[k], e_pv[k], e_clr[k], e_busy[k]}) begin
          bad++;
          $display("[TB] FAIL random r%0d cyc%0d got=%h want=%h", round, k, o_vec[k],
                   {e_data[k], e_pv[k], e_clr[k], e_busy[k]});
        end
      end
`ifdef EXTRACT_STATS_EN
      total++;
      if ({frame_count, drop_count} !== {16'(exp_frames), 16'(exp_drops)}) begin
        bad++;
        $display("[TB] FAIL random_stats r%0d got frames=%0d drops=%0d want frames=%0d drops=%0d",
                 round, frame_count, drop_count, exp_frames, exp_drops);
      end
`endif
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] payload_extractor bench start");
    test_reset();
    test_normal_frame();
    test_gap();
    test_short_frames();
    test_truncation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
